// File: rtl/uart_pixel_packer.sv
// Packs UART bytes into RGB565 pixels, buffers them in a small FIFO and issues
// them to the SDRAM writer in bursts, with frame-done and overflow flags.
module uart_pixel_packer #(
  parameter int PixelBitWidth    = 16,
  parameter int BurstLengthSDRAM = 8,
  parameter int FifoDepth        = 16,
  parameter int FrameWidth       = 640,
  parameter int FrameHeight      = 480
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             i_rx_valid,
  input  logic [7:0]                       i_rx_byte,
  input  logic                             i_resync,
  input  logic                             i_clear_ovf,
  input  logic                             i_busy_wr,
  output logic                             o_write_req,
  output logic [PixelBitWidth-1:0]         o_pixel,
  output logic [$clog2(FifoDepth+1)-1:0]   o_fifo_level,
  output logic                             o_overflow,
  output logic                             o_frame_done
);

  localparam int PtrW        = $clog2(FifoDepth);
  localparam int LvlW        = $clog2(FifoDepth + 1);
  localparam int BurstW      = $clog2(BurstLengthSDRAM + 1);
  localparam int FramePixels = FrameWidth * FrameHeight;
  localparam int FrameW      = (FramePixels > 1) ? $clog2(FramePixels) : 1;

  localparam logic [1:0] ST_ISSUE   = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

  logic [PixelBitWidth-1:0] mem [FifoDepth];
  logic [PtrW-1:0]          wr_ptr, rd_ptr;
  logic [LvlW-1:0]          count;
  logic [1:0]               state;
  logic [BurstW-1:0]        burst_cnt;
  logic [FrameW-1:0]        frame_cnt;
  logic                     phase_lsb;
  logic [7:0]               msb_byte;

  logic                     full, empty, pop, push_req, push_ok, ovf_set;
  logic [PixelBitWidth-1:0] push_data;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    full      = 1'b0;
    empty     = 1'b0;
    pop       = 1'b0;
    push_req  = 1'b0;
    push_ok   = 1'b0;
    ovf_set   = 1'b0;
    push_data = {msb_byte, i_rx_byte};

    full     = (count == LvlW'(FifoDepth));
    empty    = (count == '0);
    pop      = (state == ST_ISSUE) && !empty && !i_busy_wr;
    // Resync wins over a same-cycle byte; that byte never reaches the FIFO.
    push_req = i_rx_valid && phase_lsb && !i_resync;
    // A pop in the same cycle frees the slot the push needs.
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && !push_ok;
  end

  // NOTE: the pixel storage has no reset; stale contents are unreachable because the pointers and count are reset.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase_lsb    <= 1'b0;
      msb_byte     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      state        <= ST_ISSUE;
      burst_cnt    <= '0;
      frame_cnt    <= '0;
      o_write_req  <= 1'b0;
      o_pixel      <= '0;
      o_overflow   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      if (i_resync) begin
        phase_lsb <= 1'b0;
      end else if (i_rx_valid) begin
        if (!phase_lsb) msb_byte <= i_rx_byte;
        phase_lsb <= !phase_lsb;
      end

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (ovf_set)          o_overflow <= 1'b1;
      else if (i_clear_ovf) o_overflow <= 1'b0;

      o_write_req  <= pop;
      o_frame_done <= pop && (frame_cnt == FrameW'(FramePixels - 1));
      if (pop) begin
        o_pixel <= mem[rd_ptr];
        if (frame_cnt == FrameW'(FramePixels - 1)) frame_cnt <= '0;
        else                                         frame_cnt <= frame_cnt + 1'b1;
      end

      // The writer's busy lags its last request, so wait to see it rise and fall.
      case (state)
        ST_ISSUE: begin
          if (pop) begin
            if (burst_cnt == BurstW'(BurstLengthSDRAM - 1)) begin
              burst_cnt <= '0;
              state     <= ST_WAIT_HI;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        ST_WAIT_HI: if (i_busy_wr)  state <= ST_WAIT_LO;
        ST_WAIT_LO: if (!i_busy_wr) state <= ST_ISSUE;
        default:    state <= ST_ISSUE;
      endcase
    end
  end

  assign o_fifo_level = count;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Directed bench for uart_pixel_packer, built with a tiny 4x2 frame.
module tb_uart_pixel_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid, resync, clear_ovf, busy_wr;
  logic [7:0]  rx_byte;
  logic        write_req, overflow, frame_done;
  logic [15:0] pixel;
  logic [4:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] q_pix [$];
  logic        q_done[$];
  int          q_cyc [$];

  uart_pixel_packer #(
    .PixelBitWidth(16), .BurstLengthSDRAM(8), .FifoDepth(16),
    .FrameWidth(4), .FrameHeight(2)
  ) dut (
    .CLK(clk), .RST(rst_n),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .i_resync(resync),
    .i_clear_ovf(clear_ovf), .i_busy_wr(busy_wr),
    .o_write_req(write_req), .o_pixel(pixel), .o_fifo_level(fifo_level),
    .o_overflow(overflow), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst_n && write_req) begin
      q_pix.push_back(pixel);
      q_done.push_back(frame_done);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int k);
    logic [7:0] hi, lo;
    hi = 8'(8'h10 + k);
    lo = 8'(8'h80 + k);
    return {hi, lo};
  endfunction

  task automatic clear_q();
    q_pix.delete();
    q_done.delete();
    q_cyc.delete();
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic rs, input logic clr);
    @(negedge clk);
    rx_valid = v; rx_byte = b; resync = rs; clear_ovf = clr;
    @(negedge clk);
    rx_valid = 1'b0; resync = 1'b0; clear_ovf = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic send_pixel(input logic [15:0] p);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_byte = '0; resync = 1'b0; clear_ovf = 1'b0; busy_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic busy_pulse(input int n);
    @(negedge clk); busy_wr = 1'b1;
    repeat (n) @(negedge clk);
    busy_wr = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_req",   write_req,  1'b0);
    check("rst_pixel", pixel,      16'h0);
    check("rst_level", fifo_level, 5'd0);
    check("rst_ovf",   overflow,   1'b0);
    check("rst_done",  frame_done, 1'b0);

    // 1: single pixel passes straight through
    send_pixel(16'hF800);
    wait_cycles(2);
    check("t1_count", q_pix.size(), 1);
    if (q_pix.size() > 0) check("t1_pixel", q_pix[0], 16'hF800);
    check("t1_level", fifo_level, 5'd0);

    // 2: 16 preloaded pixels go out as two bursts of 8
    do_reset();
    busy_wr = 1'b1;
    for (int k = 0; k < 16; k++) send_pixel(pix(k));
    check("t2_level_full", fifo_level, 5'd16);
    check("t2_no_req_busy", q_pix.size(), 0);
    @(negedge clk); busy_wr = 1'b0;
    wait_cycles(12);
    check("t2_burst1", q_pix.size(), 8);
    for (int i = 1; i < 8 && i < q_cyc.size(); i++)
      check($sformatf("t2_consec%0d", i), q_cyc[i] - q_cyc[0], i);
    @(negedge clk); busy_wr = 1'b1;
    wait_cycles(3);
    check("t2_gap", q_pix.size(), 8);
    @(negedge clk); busy_wr = 1'b0;
    wait_cycles(12);
    check("t2_total", q_pix.size(), 16);
    for (int i = 0; i < 16 && i < q_pix.size(); i++)
      check($sformatf("t2_pix%0d", i), q_pix[i], pix(i));
    check("t2_level_empty", fifo_level, 5'd0);

    // 3: overflow, sticky flag, clear, and set-beats-clear
    do_reset();
    busy_wr = 1'b1;
    for (int k = 0; k < 17; k++) send_pixel(pix(k));
    check("t3_level", fifo_level, 5'd16);
    check("t3_ovf", overflow, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3_clear", overflow, 1'b0);
    send_byte(8'hEE);
    drive(1'b1, 8'hEF, 1'b0, 1'b1);
    check("t3_set_wins", overflow, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3_clear2", overflow, 1'b0);
    @(negedge clk); busy_wr = 1'b0;
    wait_cycles(12);
    busy_pulse(3);
    wait_cycles(12);
    check("t3_drained", q_pix.size(), 16);
    if (q_pix.size() == 16) check("t3_last", q_pix[15], pix(15));

    // 4: resync discards a pending half pixel and a same-cycle byte
    do_reset();
    send_byte(8'hAB);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    send_pixel(16'h1234);
    wait_cycles(3);
    check("t4_count", q_pix.size(), 1);
    if (q_pix.size() > 0) check("t4_pixel", q_pix[0], 16'h1234);
    send_byte(8'hAB);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    send_pixel(16'h5678);
    wait_cycles(3);
    check("t4_count2", q_pix.size(), 2);
    if (q_pix.size() > 1) check("t4_pixel2", q_pix[1], 16'h5678);

    // 5: frame done on issued pixels 8 and 16 with a 4x2 frame
    do_reset();
    for (int k = 0; k < 8; k++) send_pixel(pix(k));
    wait_cycles(3);
    busy_pulse(2);
    for (int k = 8; k < 16; k++) send_pixel(pix(k));
    wait_cycles(3);
    check("t5_count", q_done.size(), 16);
    for (int i = 0; i < 16 && i < q_done.size(); i++)
      check($sformatf("t5_done%0d", i + 1), q_done[i], (i == 7 || i == 15));

    // 6: asynchronous reset mid-burst
    do_reset();
    busy_wr = 1'b1;
    for (int k = 0; k < 17; k++) send_pixel(pix(k));
    @(negedge clk); busy_wr = 1'b0;
    for (int t = 0; t < 20 && q_pix.size() < 3; t++) @(negedge clk);
    check("t6_burst_started", q_pix.size() >= 3, 1'b1);
    @(posedge clk); #2;
    check("t6_req_before", write_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_req",   write_req,  1'b0);
    check("t6_pixel", pixel,      16'h0);
    check("t6_level", fifo_level, 5'd0);
    check("t6_ovf",   overflow,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    send_pixel(16'h1357);
    wait_cycles(3);
    check("t6_after_count", q_pix.size(), 1);
    if (q_pix.size() > 0) check("t6_after_pixel", q_pix[0], 16'h1357);
    check("t6_after_level", fifo_level, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
